// File: rtl/stream_pkg.sv
// Shared constants and sizing helpers for the stream collector family.
// Mode selectors, lock-state encoding and select-width helpers live here.
package stream_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } lockState_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   // Select fields are never narrower than one bit, even for a single channel.
   function automatic int selWidth(input int channels);
      return (clog2(channels) > 1) ? clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/stream_arbiter.sv
// Combinational grant selection: first asserted request at or above iBase,
// wrapping modulo CHANNELS. Returns a one-hot grant and its index.
module stream_arbiter
   import stream_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int SELW     = selWidth(CHANNELS)
) (
   input  logic [CHANNELS-1:0] iRequest,
   input  logic [SELW-1:0]     iBase,
   output logic [CHANNELS-1:0] oGrant,
   output logic [SELW-1:0]     oIndex,
   output logic                oAny
);

   logic [SELW-1:0] idx;

   always_comb begin
      oGrant = '0;
      oIndex = '0;
      oAny   = 1'b0;
      idx    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         idx = SELW'((int'(iBase) + i) % CHANNELS);
         if (!oAny && iRequest[idx]) begin
            oAny        = 1'b1;
            oGrant[idx] = 1'b1;
            oIndex      = idx;
         end
      end
   end

endmodule

// File: rtl/stream_collector_n.sv
// N-to-1 packet-aware stream collector with one registered output stage.
// Packets (beats up to iLast) are never interleaved between channels.
module stream_collector_n
   import stream_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32,
   parameter int MODE     = 0,
   parameter int PRIORITY = 0
) (
   input  logic                          iCLK,
   input  logic                          iRST_n,
   input  logic [CHANNELS-1:0]           iValid_AS,
   output logic [CHANNELS-1:0]           oReady_AS,
   input  logic [CHANNELS*WIDTH-1:0]     iData_AS,
   input  logic [CHANNELS-1:0]           iLast_AS,
   output logic                          oValid_BM,
   input  logic                          iReady_BM,
   output logic [selWidth(CHANNELS)-1:0] oSelect_BM,
   output logic [WIDTH-1:0]              oData_BM,
   output logic                          oLast_BM
);

   localparam int SELW = selWidth(CHANNELS);

   // Handshake: a beat moves on any port at a rising edge where its valid
   // and ready are both high; ready never waits on the same cycle's valid
   // of the output side, only on whether the output register can be refilled.

   lockState_t            lockState;
   logic [SELW-1:0]       ownCh;
   logic                  holdActive;
   logic [SELW-1:0]       rrPtr;

   logic                  acceptOk;
   logic [SELW-1:0]       base;
   logic [CHANNELS-1:0]   arbGrant;
   logic [SELW-1:0]       arbIndex;
   logic                  arbAny;
   logic                  holdHit;
   logic                  pinned;
   logic [CHANNELS-1:0]   grantVec;
   logic [SELW-1:0]       grantIdx;
   logic                  grantAny;
   logic                  accept;
   logic [WIDTH-1:0]      selData;
   logic                  selLast;

   assign acceptOk = !oValid_BM || iReady_BM;

   always_comb begin
      base = SELW'(PRIORITY);
      if (MODE == MODE_RR) begin
         base = (rrPtr == SELW'(CHANNELS - 1)) ? '0 : rrPtr + 1'b1;
      end
   end

   stream_arbiter #(
      .CHANNELS (CHANNELS),
      .SELW     (SELW)
   ) uArbiter (
      .iRequest (iValid_AS),
      .iBase    (base),
      .oGrant   (arbGrant),
      .oIndex   (arbIndex),
      .oAny     (arbAny)
   );

   // A stalled-but-valid grant is pinned so a newly valid channel cannot steal it.
   assign holdHit  = holdActive && iValid_AS[ownCh];
   assign pinned   = (lockState == ST_LOCKED) || holdHit;
   assign grantIdx = pinned ? ownCh : arbIndex;
   assign grantAny = pinned || arbAny;
   assign grantVec = pinned ? ({{(CHANNELS-1){1'b0}}, 1'b1} << ownCh) : arbGrant;

   assign oReady_AS = grantVec & iValid_AS & {CHANNELS{acceptOk & iRST_n}};
   assign accept    = |oReady_AS;

   always_comb begin
      selData = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (grantIdx == SELW'(k)) selData = iData_AS[k*WIDTH +: WIDTH];
      end
   end

   assign selLast = iLast_AS[grantIdx];

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         oValid_BM  <= 1'b0;
         oData_BM   <= '0;
         oSelect_BM <= '0;
         oLast_BM   <= 1'b0;
         lockState  <= ST_UNLOCKED;
         ownCh      <= '0;
         holdActive <= 1'b0;
         rrPtr      <= SELW'(CHANNELS - 1);
      end else begin
         if (accept) begin
            oValid_BM  <= 1'b1;
            oData_BM   <= selData;
            oSelect_BM <= grantIdx;
            oLast_BM   <= selLast;
            rrPtr      <= grantIdx;
         end else if (iReady_BM) begin
            oValid_BM  <= 1'b0;
         end

         holdActive <= 1'b0;
         case (lockState)
            ST_UNLOCKED: begin
               if (accept && !selLast) begin
                  lockState <= ST_LOCKED;
                  ownCh     <= grantIdx;
               end else if (grantAny && iValid_AS[grantIdx] && !acceptOk) begin
                  holdActive <= 1'b1;
                  ownCh      <= grantIdx;
               end
            end
            ST_LOCKED: begin
               if (accept && selLast) lockState <= ST_UNLOCKED;
            end
            default: lockState <= ST_UNLOCKED;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_collector_n.sv
// Directed bench for stream_collector_n: fixed priority, round-robin,
// packet lock, backpressure and mid-packet reset.
module tb_stream_collector_n;

   logic clk;
   logic rst_n;

   logic [3:0]   v0, r0, l0;
   logic [127:0] d0;
   logic         ov0, ir0, ol0;
   logic [1:0]   os0;
   logic [31:0]  od0;

   logic [3:0]   v1, r1, l1;
   logic [127:0] d1;
   logic         ov1, ir1, ol1;
   logic [1:0]   os1;
   logic [31:0]  od1;

   int checks;
   int errors;
   int deliverCount;

   stream_collector_n #(.CHANNELS(4), .WIDTH(32), .MODE(0), .PRIORITY(2)) dut0 (
      .iCLK(clk), .iRST_n(rst_n),
      .iValid_AS(v0), .oReady_AS(r0), .iData_AS(d0), .iLast_AS(l0),
      .oValid_BM(ov0), .iReady_BM(ir0), .oSelect_BM(os0), .oData_BM(od0), .oLast_BM(ol0)
   );

   stream_collector_n #(.CHANNELS(4), .WIDTH(32), .MODE(1), .PRIORITY(0)) dut1 (
      .iCLK(clk), .iRST_n(rst_n),
      .iValid_AS(v1), .oReady_AS(r1), .iData_AS(d1), .iLast_AS(l1),
      .oValid_BM(ov1), .iReady_BM(ir1), .oSelect_BM(os1), .oData_BM(od1), .oLast_BM(ol1)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time budget");
      $fatal(1);
   end

   always @(posedge clk) begin
      if (rst_n && ov1 && ir1 && od1 == 32'hA5A5_0001) deliverCount <= deliverCount + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setD1(input int ch, input logic [31:0] val);
      d1[ch*32 +: 32] = val;
   endtask

   task automatic test_reset();
      v1 = 4'b1111;
      #2;
      checks++;
      if (ov0 !== 1'b0 || od0 !== 32'h0 || os0 !== 2'd0 || ol0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dut0: valid=%b data=%h sel=%0d last=%b expected all zero", ov0, od0, os0, ol0);
      end
      checks++;
      if (ov1 !== 1'b0 || od1 !== 32'h0 || os1 !== 2'd0 || ol1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dut1: valid=%b data=%h sel=%0d last=%b expected all zero", ov1, od1, os1, ol1);
      end
      checks++;
      if (r1 !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 0000", r1);
      end
      v1 = 4'b0000;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (ov1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_valid: got %b expected 0", ov1);
      end
   endtask

   task automatic test_fixed_priority();
      logic [31:0] expData;
      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < 4; k++) d0[k*32 +: 32] = 32'((k << 8) | n);
         v0 = 4'b1111;
         l0 = 4'b1111;
         ir0 = 1'b1;
         expData = 32'((2 << 8) | n);
         #1;
         checks++;
         if (r0 !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_ready beat %0d: got %b expected 0100", n, r0);
         end
         tick();
         checks++;
         if (ov0 !== 1'b1 || os0 !== 2'd2 || od0 !== expData) begin
            errors++;
            $display("FAIL fixed_out beat %0d: valid=%b sel=%0d data=%h expected 1/2/%h", n, ov0, os0, od0, expData);
         end
      end
      v0 = 4'b0000;
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] expSel [6];
      logic [31:0] expData;
      expSel = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < 4; k++) setD1(k, 32'h2000_0000 | 32'((k << 4) | n));
         v1 = 4'b1011;
         l1 = 4'b1111;
         ir1 = 1'b1;
         expData = 32'h2000_0000 | 32'((int'(expSel[n]) << 4) | n);
         #1;
         checks++;
         if (r1 !== (4'b0001 << expSel[n])) begin
            errors++;
            $display("FAIL rr_ready beat %0d: got %b expected channel %0d", n, r1, expSel[n]);
         end
         tick();
         checks++;
         if (ov1 !== 1'b1 || os1 !== expSel[n] || od1 !== expData) begin
            errors++;
            $display("FAIL rr_out beat %0d: valid=%b sel=%0d data=%h expected 1/%0d/%h", n, ov1, os1, od1, expSel[n], expData);
         end
      end
      v1 = 4'b0000;
      tick();
      checks++;
      if (ov1 !== 1'b0) begin
         errors++;
         $display("FAIL rr_drain: valid=%b expected 0", ov1);
      end
   endtask

   task automatic test_lock();
      logic [3:0] vSeq [7];
      logic [3:0] rExp [7];
      logic       lCh1 [7];
      logic [31:0] dCh1 [7];
      logic       ovExp [7];
      logic [1:0] osExp [7];
      vSeq  = '{4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b0001};
      rExp  = '{4'b0001, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0001};
      lCh1  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      dCh1  = '{32'h0, 32'h3100_0001, 32'h0, 32'h3100_0002, 32'h0, 32'h3100_0003, 32'h0};
      ovExp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      osExp = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
      ir1 = 1'b1;
      l1 = 4'b0001;
      setD1(0, 32'h3000_0000);
      for (int s = 0; s < 7; s++) begin
         v1 = vSeq[s];
         l1[1] = lCh1[s];
         setD1(1, dCh1[s]);
         #1;
         checks++;
         if (r1 !== rExp[s]) begin
            errors++;
            $display("FAIL lock_ready step %0d: got %b expected %b", s, r1, rExp[s]);
         end
         tick();
         checks++;
         if (ov1 !== ovExp[s] || (ovExp[s] && os1 !== osExp[s])) begin
            errors++;
            $display("FAIL lock_out step %0d: valid=%b sel=%0d expected %b/%0d", s, ov1, os1, ovExp[s], osExp[s]);
         end
         if (ovExp[s] && osExp[s] == 2'd1) begin
            checks++;
            if (od1 !== dCh1[s] || ol1 !== lCh1[s]) begin
               errors++;
               $display("FAIL lock_data step %0d: data=%h last=%b expected %h/%b", s, od1, ol1, dCh1[s], lCh1[s]);
            end
         end
      end
      v1 = 4'b0000;
      tick();
   endtask

   task automatic test_backpressure();
      v1 = 4'b0001;
      l1 = 4'b1111;
      ir1 = 1'b1;
      setD1(0, 32'hA5A5_0001);
      tick();
      checks++;
      if (ov1 !== 1'b1 || od1 !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL bp_fill: valid=%b data=%h expected 1/a5a50001", ov1, od1);
      end
      ir1 = 1'b0;
      setD1(0, 32'hA5A5_0002);
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (r1 !== 4'b0000) begin
            errors++;
            $display("FAIL bp_ready cycle %0d: got %b expected 0000", c, r1);
         end
         tick();
         checks++;
         if (ov1 !== 1'b1 || od1 !== 32'hA5A5_0001 || os1 !== 2'd0 || ol1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: valid=%b data=%h sel=%0d last=%b expected 1/a5a50001/0/1", c, ov1, od1, os1, ol1);
         end
      end
      ir1 = 1'b1;
      #1;
      checks++;
      if (r1 !== 4'b0001) begin
         errors++;
         $display("FAIL bp_release_ready: got %b expected 0001", r1);
      end
      tick();
      checks++;
      if (ov1 !== 1'b1 || od1 !== 32'hA5A5_0002) begin
         errors++;
         $display("FAIL bp_next: valid=%b data=%h expected 1/a5a50002", ov1, od1);
      end
      v1 = 4'b0000;
      tick();
      checks++;
      if (ov1 !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: valid=%b expected 0", ov1);
      end
      checks++;
      if (deliverCount !== 1) begin
         errors++;
         $display("FAIL bp_once: delivered %0d times expected 1", deliverCount);
      end
   endtask

   task automatic test_reset_mid_packet();
      v1 = 4'b0100;
      l1 = 4'b0000;
      ir1 = 1'b1;
      setD1(2, 32'h4200_0001);
      #1;
      checks++;
      if (r1 !== 4'b0100) begin
         errors++;
         $display("FAIL rst_pkt_ready: got %b expected 0100", r1);
      end
      tick();
      checks++;
      if (ov1 !== 1'b1 || os1 !== 2'd2) begin
         errors++;
         $display("FAIL rst_pkt_start: valid=%b sel=%0d expected 1/2", ov1, os1);
      end
      ir1 = 1'b0;
      setD1(2, 32'h4200_0002);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ov1 !== 1'b0 || od1 !== 32'h0 || os1 !== 2'd0 || ol1 !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: valid=%b data=%h sel=%0d last=%b expected all zero", ov1, od1, os1, ol1);
      end
      checks++;
      if (r1 !== 4'b0000) begin
         errors++;
         $display("FAIL rst_async_ready: got %b expected 0000", r1);
      end
      tick();
      rst_n = 1'b1;
      ir1 = 1'b1;
      v1 = 4'b0111;
      l1 = 4'b1111;
      setD1(0, 32'h5000_0000);
      setD1(1, 32'h5100_0000);
      setD1(2, 32'h5200_0000);
      #1;
      checks++;
      if (r1 !== 4'b0001) begin
         errors++;
         $display("FAIL rst_first_ready: got %b expected 0001", r1);
      end
      tick();
      checks++;
      if (ov1 !== 1'b1 || os1 !== 2'd0 || od1 !== 32'h5000_0000) begin
         errors++;
         $display("FAIL rst_first_grant: valid=%b sel=%0d data=%h expected 1/0/50000000", ov1, os1, od1);
      end
      v1 = 4'b0000;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      deliverCount = 0;
      rst_n = 1'b0;
      v0 = '0; l0 = '0; d0 = '0; ir0 = 1'b1;
      v1 = '0; l1 = '0; d1 = '0; ir1 = 1'b1;
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_lock();
      test_backpressure();
      test_reset_mid_packet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
